uart_tx_mmio: RTL

//  Memory-mapped UART transmitter peripheral at word address 31 (the UART slot); the responder to the address decoder's write strobe.
//  A qualified store (WE1=1) with WD[31]=0 enqueues the byte WD[7:0]; the shifter serialises it 8N1, LSB first, on tx.
//  RD returns a status word; the top-level read mux selects it when RDSet=2'b01.

---
 rtl/uart_tx_mmio.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter for the UART word slot.
// A plain store enqueues WD[7:0] into a small TX FIFO. A store with
// WD[31] set is a control write that clears the sticky overflow flag.
// A shifter drains the FIFO and sends each byte LSB first on tx.
// RD is a status word built from registered state only.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity
// bit after the data bits (8E1). The default build sends 8N1.
module uart_tx_mmio #(
  parameter int unsigned Width        = 32,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE1,
  input  logic [Width-1:0] WD,
  output logic [Width-1:0] RD,
  output logic             tx
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // FSM and shifter state
  state_t         r_state;
  state_t         w_state_nxt;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           w_tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic           r_parity;
`endif

  // FIFO state
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf;

  // Decoded bus and handshake signals
  logic           w_full;
  logic           w_empty;
  logic           w_data_wr;
  logic           w_ctrl_wr;
  logic           w_push;
  logic           w_pop;
  logic           w_tick;
  logic [2:0]     w_cnt3;
  logic           w_unused_wd;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_data_wr = WE1 & ~WD[31];
  assign w_ctrl_wr = WE1 & WD[31];
  // The full flag is taken from the pre-edge count. A store into a full
  // FIFO is dropped even if the shifter pops in the same cycle.
  assign w_push    = w_data_wr & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_tick    = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_cnt3    = 3'(r_count);
  assign w_unused_wd = ^WD[Width-2:8];

  // FIFO storage: the write port is the only writer. No reset is needed
  // because the pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WD[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_ctrl_wr) begin
        r_ovf <= 1'b0;
      end else if (w_data_wr && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and line-level decode. tx is registered from this, so the
  // line follows the state by one clock and every bit stays CLKS_PER_BIT wide.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_nxt = r_parity;
        if (w_tick) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Baud counter: it runs only while a frame is active and wraps each bit time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud <= '0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  // Shift register, bit index and parity: loaded on pop, advanced per data bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_shift   <= r_mem[r_rd_ptr];
      r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= ^r_mem[r_rd_ptr];
`endif
    end else if (r_state == S_DATA && w_tick) begin
      r_shift   <= {1'b0, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  // Registered serial line: it idles high and reset forces it high at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;
    end
  end

  assign tx = r_tx;

  // Status word assembled from registered state
  always_comb begin
    RD      = '0;
    RD[0]   = (r_state != S_IDLE);
    RD[1]   = w_full;
    RD[2]   = w_empty;
    RD[3]   = r_ovf;
    RD[6:4] = w_cnt3;
  end

endmodule
